// File: rtl/instruction_memory_loader.sv
// -----------------------------------------------------------------------------
// instruction_memory_loader
//
// Write side of the MIPS instruction memory. Before the pipeline runs, a
// program arrives from the UART receiver as a byte stream. This block packs
// the bytes into big-endian instruction words (first byte is the MSB). It
// writes each word to the next instruction-memory address. When the halt
// word arrives, it is written too, and then the pipeline is enabled.
//
// Ports
//   i_clock        single clock
//   i_reset        asynchronous, active-low reset
//   i_rx_data      received byte from the UART
//   i_rx_valid     one-cycle strobe, i_rx_data valid this cycle
//   i_load_req     one-cycle pulse, start or restart a program load
//   o_mem_wr_enb   instruction-memory write strobe (one cycle per word)
//   o_mem_wr_addr  word address of the write
//   o_mem_wr_data  assembled instruction word
//   o_word_count   words written in the current load
//   o_loading      high while receiving or writing
//   o_done         high once the halt word has been written
//   o_error        high if the memory filled up without a halt word
//   o_cpu_enable   pipeline enable, high only after a successful load
//
// Every output comes from a register or is decoded from the state register.
// No input reaches an output combinationally.
// -----------------------------------------------------------------------------
module instruction_memory_loader #(
    parameter int                NB_DATA   = 32,
    parameter int                NB_BYTE   = 8,
    parameter int                NB_ADDR   = 10,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_load_req,
    output logic               o_mem_wr_enb,
    output logic [NB_ADDR-1:0] o_mem_wr_addr,
    output logic [NB_DATA-1:0] o_mem_wr_data,
    output logic [NB_ADDR:0]   o_word_count,
    output logic               o_loading,
    output logic               o_done,
    output logic               o_error,
    output logic               o_cpu_enable
);

    // Number of bytes per instruction word, and the counter that tracks them.
    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [BCNT_W-1:0]  BCNT_LAST = BCNT_W'(BYTES_PER_WORD - 1);
    localparam logic [BCNT_W-1:0]  BCNT_ONE  = BCNT_W'(1);
    localparam logic [NB_ADDR-1:0] ADDR_MAX  = '1;
    localparam logic [NB_ADDR-1:0] ADDR_ONE  = NB_ADDR'(1);
    localparam logic [NB_ADDR:0]   CNT_ONE   = (NB_ADDR + 1)'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // Datapath registers
    logic [NB_DATA-1:0] word;
    logic [BCNT_W-1:0]  byte_cnt;
    logic [NB_ADDR-1:0] addr;
    logic [NB_ADDR:0]   word_count;

    // Control decoded from the current state and inputs
    logic clear_load;   // start/restart a load: counters and partial word cleared
    logic shift_byte;   // accept i_rx_data into the word shift register
    logic advance_addr; // word written and more may follow: move to next address
    logic count_word;   // a word is written this cycle

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    always_comb begin
        next_state   = state;
        clear_load   = 1'b0;
        shift_byte   = 1'b0;
        advance_addr = 1'b0;
        count_word   = 1'b0;

        case (state)
            IDLE: begin
                // Bytes seen before a load request are line noise and are ignored.
                if (i_load_req) begin
                    clear_load = 1'b1;
                    next_state = RECV;
                end
            end

            RECV: begin
                // A load request wins over a byte in the same cycle. The byte
                // and any partial word are thrown away.
                if (i_load_req) begin
                    clear_load = 1'b1;
                    next_state = RECV;
                end else if (i_rx_valid) begin
                    shift_byte = 1'b1;
                    if (byte_cnt == BCNT_LAST) begin
                        next_state = WRITE;
                    end
                end
            end

            WRITE: begin
                // The write strobe comes from the state alone. A restart in
                // this cycle therefore still lets the word reach memory.
                count_word = 1'b1;
                if (i_load_req) begin
                    clear_load = 1'b1;
                    next_state = RECV;
                end else if (word == HALT_WORD) begin
                    next_state = DONE;
                end else if (addr == ADDR_MAX) begin
                    next_state = ERROR;
                end else begin
                    advance_addr = 1'b1;
                    next_state   = RECV;
                    // A byte in the write cycle is byte 0 of the next word.
                    // This keeps one byte per cycle lossless.
                    if (i_rx_valid) begin
                        shift_byte = 1'b1;
                    end
                end
            end

            DONE, ERROR: begin
                if (i_load_req) begin
                    clear_load = 1'b1;
                    next_state = RECV;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Word assembly, byte counter, address and word count
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            word       <= '0;
            byte_cnt   <= '0;
            addr       <= '0;
            word_count <= '0;
        end else if (clear_load) begin
            word       <= '0;
            byte_cnt   <= '0;
            addr       <= '0;
            word_count <= '0;
        end else begin
            if (shift_byte) begin
                word <= {word[NB_DATA-NB_BYTE-1:0], i_rx_data};
                if (byte_cnt == BCNT_LAST) begin
                    byte_cnt <= '0;
                end else begin
                    byte_cnt <= byte_cnt + BCNT_ONE;
                end
            end
            if (advance_addr) begin
                addr <= addr + ADDR_ONE;
            end
            if (count_word) begin
                word_count <= word_count + CNT_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs decoded from registered state
    // -------------------------------------------------------------------------
    // Address and data are forced to zero outside the write cycle. This way
    // the memory bus is quiet while idle and reads all-zero in reset.
    always_comb begin
        o_mem_wr_enb  = (state == WRITE);
        o_mem_wr_addr = (state == WRITE) ? addr : '0;
        o_mem_wr_data = (state == WRITE) ? word : '0;
        o_word_count  = word_count;
        o_loading     = (state == RECV) || (state == WRITE);
        o_done        = (state == DONE);
        o_error       = (state == ERROR);
        o_cpu_enable  = (state == DONE);
    end

endmodule

// File: doc/instruction_memory_loader.md
# instruction_memory_loader

Writes a program into the MIPS instruction memory before execution starts. It takes a byte stream from the UART receiver, assembles big-endian 32-bit instruction words, and writes them to consecutive instruction-memory addresses. When the halt word arrives, it raises the enable that lets the pipeline run. It is the write side of the instruction memory; the fetch unit is the read side.

## Interface
Parameters:
- NB_DATA, 32, instruction word width
- NB_BYTE, 8, width of the received byte
- NB_ADDR, 10, instruction memory word-address width (depth 2^NB_ADDR)
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker

Ports (clock and reset as in the rest of the design; reset is asynchronous and active-low):
- i_clock  in  1  single clock
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle
- i_load_req  in  1  one-cycle pulse; start or restart a program load
- o_mem_wr_enb  out  1  instruction-memory write strobe
- o_mem_wr_addr  out  NB_ADDR  word address of the write
- o_mem_wr_data  out  NB_DATA  assembled instruction word
- o_word_count  out  NB_ADDR+1  number of words written in the current load
- o_loading  out  1  high in RECV or WRITE
- o_done  out  1  high in DONE
- o_error  out  1  high in ERROR (memory filled without a halt word)
- o_cpu_enable  out  1  drives the pipeline i_enable; high only in DONE

## Operation
- States: IDLE, RECV, WRITE, DONE, ERROR.
- Reset (i_reset=0): state IDLE. Shift register, byte counter, address and word count are all 0. All outputs are 0.
- IDLE:
  - i_rx_valid is ignored.
  - i_load_req clears the byte counter, address and word count, then goes to RECV.
- RECV:
  - On each i_rx_valid: word <= {word[NB_DATA-NB_BYTE-1:0], i_rx_data}, so the first byte is the MSB; the byte counter increments.
  - On the 4th byte the counter wraps to 0 and the state goes to WRITE.
- WRITE (exactly one cycle):
  - o_mem_wr_enb=1, o_mem_wr_addr=address, o_mem_wr_data=word; word count increments.
  - If word == HALT_WORD: go to DONE. The halt word is itself written.
  - Else, if address == 2^NB_ADDR-1: go to ERROR.
  - Else: address increments (modulo 2^NB_ADDR) and the state returns to RECV.
- Byte arriving during WRITE:
  - If the next state is RECV, the byte is accepted as byte 0 of the next word.
  - If the next state is DONE or ERROR, the byte is dropped.
- DONE: o_done=1, o_cpu_enable=1. Bytes are ignored. i_load_req restarts the load as from IDLE.
- ERROR: o_error=1, o_cpu_enable=0. Bytes are ignored. i_load_req restarts the load.
- i_load_req in RECV or WRITE:
  - Aborts the current load: counters are cleared, state goes to RECV, a partial word is discarded.
  - A WRITE in progress in that cycle still issues its write.
  - i_load_req takes priority over a simultaneous i_rx_valid; that byte is dropped.
- Asynchronous reset mid-load returns to IDLE at once, with all outputs 0. Memory contents are not cleared.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

## Timing
- i_load_req at edge k: o_loading=1 from cycle k+1.
- 4th byte strobe at edge N: o_mem_wr_enb=1 during cycle N+1, with address, data and word count stable.
- o_word_count reflects the new value from cycle N+2.
- Halt word written in cycle N+1: o_done=1 and o_cpu_enable=1 from cycle N+2; o_loading=0 from N+2.
- Reload from DONE: o_cpu_enable falls in the cycle after the i_load_req edge.
- Maximum byte rate: one byte per cycle, no bytes lost, including a byte in the WRITE cycle.

## Test plan
- Basic load:
  - Stimulus: reset, i_load_req, then bytes 20 08 00 05 FF FF FF FF.
  - Required: writes (addr 0, 0x20080005) and (addr 1, 0xFFFFFFFF); then o_done=1, o_cpu_enable=1, o_word_count=2.
- Pre-load noise:
  - Stimulus: bytes AA BB arrive in IDLE, then i_load_req, then FF FF FF FF.
  - Required: single write (addr 0, 0xFFFFFFFF); o_word_count=1.
- Overflow with NB_ADDR=2:
  - Stimulus: 4 non-halt words (16 bytes of 0x11).
  - Required: 4 writes at addresses 0–3, then o_error=1, o_cpu_enable=0, o_word_count=4; further bytes produce no writes.
- Restart mid-word:
  - Stimulus: i_load_req, bytes 12 34, i_load_req, then FF FF FF FF.
  - Required: single write (addr 0, 0xFFFFFFFF); no write containing 0x1234.
- Back-to-back bytes:
  - Stimulus: i_rx_valid held high for 8 cycles with bytes 00 00 00 01 FF FF FF FF.
  - Required: writes (addr 0, 0x00000001) and (addr 1, 0xFFFFFFFF); no byte lost.
- Asynchronous reset mid-load:
  - Stimulus: assert i_reset between bytes 2 and 3 of the second word.
  - Required: all outputs 0 immediately, state IDLE; a subsequent i_load_req with FF FF FF FF writes addr 0.
